// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional NIBBLE_SERIAL_OVF_EN adds a signed-overflow output to the top.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nsa_fsm.sv
// Control for the nibble-serial adder.
// Holds the state register, the pass counter and both handshakes.
import nsa_pkg::*;

module nsa_fsm #(
    parameter int NIBBLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic accept,
    output logic run,
    output logic last
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t        state;
    logic [CW-1:0] cnt;

    assign accept = in_ready && in_valid;
    assign run    = (state == ST_RUN);
    assign last   = run && (cnt == CW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_RUN;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one external 4-bit slice, one nibble per cycle.
// Define NIBBLE_SERIAL_OVF_EN to add the registered out_ovf port.
import nsa_pkg::*;

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_sum,
    output logic                out_cout,
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_cin,
    input  logic [NIBBLE_W-1:0] add_s,
    input  logic                add_cout
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic                out_ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;

    logic             accept;
    logic             run;
    logic             last;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;

    nsa_fsm #(
        .NIBBLES(NIBBLES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .accept   (accept),
        .run      (run),
        .last     (last)
    );

    // Slice inputs are forced to zero whenever no pass is in flight.
    assign add_a   = run ? a_sr[NIBBLE_W-1:0] : '0;
    assign add_b   = run ? b_sr[NIBBLE_W-1:0] : '0;
    assign add_cin = run ? carry : 1'b0;
    assign out_sum = sum_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            out_cout <= 1'b0;
        end else if (accept) begin
            a_sr  <= in_a;
            b_sr  <= in_b;
            carry <= in_cin;
        end else if (run) begin
            a_sr   <= a_sr >> NIBBLE_W;
            b_sr   <= b_sr >> NIBBLE_W;
            sum_sr <= {add_s, sum_sr[WIDTH-1:NIBBLE_W]};
            carry  <= add_cout;
            if (last) begin
                out_cout <= add_cout;
            end
        end
    end

`ifdef NIBBLE_SERIAL_OVF_EN
    // Carry into the sign bit is recovered from the top slice's sum bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (last) begin
            out_ovf <= add_cout ^ (add_s[3] ^ add_a[3] ^ add_b[3]);
        end
    end
`endif

endmodule
